// File: rtl/diagcard_lpc_io_host_if.sv
// Request stream plus LPC pin bundle for the POST-code LPC host.
// The host block uses master; the bus/peripheral side uses slave.
interface diagcard_lpc_io_host_if;
    logic        s_tvalid;
    logic        s_tready;
    logic [15:0] s_taddr;
    logic [7:0]  s_tdata;
    logic [3:0]  lpc_lad_o;
    logic        lpc_lad_oe;
    logic [3:0]  lpc_lad_i;
    logic        lpc_lframe_n;
    logic        done;
    logic [1:0]  resp;

    modport master (
        input  s_tvalid,
        input  s_taddr,
        input  s_tdata,
        input  lpc_lad_i,
        output s_tready,
        output lpc_lad_o,
        output lpc_lad_oe,
        output lpc_lframe_n,
        output done,
        output resp
    );

    modport slave (
        output s_tvalid,
        output s_taddr,
        output s_tdata,
        output lpc_lad_i,
        input  s_tready,
        input  lpc_lad_o,
        input  lpc_lad_oe,
        input  lpc_lframe_n,
        input  done,
        input  resp
    );
endinterface

// File: rtl/diagcard_lpc_io_host.sv
// LPC host initiator: one I/O-write cycle per request, SYNC outcome
// reported on done/resp, abort on stalled or absent peripheral.
module diagcard_lpc_io_host #(
    parameter int unsigned WAIT_LIMIT   = 64,
    parameter int unsigned NORESP_LIMIT = 3
) (
    input logic                    clk,
    input logic                    reset,
    diagcard_lpc_io_host_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_CYCTYP,
        S_ADDR,
        S_DATA,
        S_HTAR1,
        S_HTAR2,
        S_SYNC,
        S_PTAR1,
        S_PTAR2,
        S_ABORT,
        S_ABEND
    } state_t;

    localparam logic [7:0] WAIT_LIM = 8'(WAIT_LIMIT);
    localparam logic [7:0] NR_LIM   = 8'(NORESP_LIMIT);

    localparam logic [1:0] R_OK     = 2'b00;
    localparam logic [1:0] R_SYNERR = 2'b01;
    localparam logic [1:0] R_NORESP = 2'b10;
    localparam logic [1:0] R_TMO    = 2'b11;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  nr_q, nr_d;
    logic [1:0]  rslt_q, rslt_d;
    logic [1:0]  resp_q, resp_d;
    logic        done_q, done_d;
    logic        ready_q, ready_d;
    logic [3:0]  lad_q, lad_d;
    logic        oe_q, oe_d;
    logic        frame_n_q, frame_n_d;

    logic [7:0]  cnt_inc;
    logic [7:0]  nr_inc;

    // Both SYNC counters saturate so long limits never wrap.
    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    assign nr_inc  = (nr_q == 8'hFF) ? nr_q : nr_q + 8'd1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        nr_d    = nr_q;
        rslt_d  = rslt_q;
        resp_d  = resp_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.s_tvalid && ready_q) begin
                    addr_d  = bus.s_taddr;
                    data_d  = bus.s_tdata;
                    state_d = S_START;
                end
            end
            S_START: state_d = S_CYCTYP;
            S_CYCTYP: begin
                idx_d   = 2'd0;
                state_d = S_ADDR;
            end
            S_ADDR: begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    idx_d   = 2'd0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd1) begin
                    idx_d   = 2'd0;
                    state_d = S_HTAR1;
                end
            end
            S_HTAR1: state_d = S_HTAR2;
            S_HTAR2: begin
                cnt_d   = 8'd0;
                nr_d    = 8'd0;
                state_d = S_SYNC;
            end
            S_SYNC: begin
                cnt_d = cnt_inc;
                case (bus.lpc_lad_i)
                    4'b0000: begin
                        rslt_d  = R_OK;
                        state_d = S_PTAR1;
                    end
                    4'b1010: begin
                        rslt_d  = R_SYNERR;
                        state_d = S_PTAR1;
                    end
                    4'b0101, 4'b0110: begin
                        nr_d = 8'd0;
                        if (cnt_inc >= WAIT_LIM) begin
                            rslt_d  = R_TMO;
                            idx_d   = 2'd0;
                            state_d = S_ABORT;
                        end
                    end
                    // Undefined codes count as an undriven bus.
                    default: begin
                        nr_d = nr_inc;
                        if (nr_inc >= NR_LIM) begin
                            rslt_d  = R_NORESP;
                            idx_d   = 2'd0;
                            state_d = S_ABORT;
                        end else if (cnt_inc >= WAIT_LIM) begin
                            rslt_d  = R_TMO;
                            idx_d   = 2'd0;
                            state_d = S_ABORT;
                        end
                    end
                endcase
            end
            S_PTAR1: state_d = S_PTAR2;
            S_PTAR2: begin
                done_d  = 1'b1;
                resp_d  = rslt_q;
                state_d = S_IDLE;
            end
            S_ABORT: begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = S_ABEND;
                end
            end
            S_ABEND: begin
                done_d  = 1'b1;
                resp_d  = rslt_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pin values are decoded from the next state so they launch
    // from flops in the same clock the state becomes visible.
    always_comb begin
        ready_d   = (state_d == S_IDLE);
        frame_n_d = 1'b1;
        oe_d      = 1'b0;
        lad_d     = 4'hF;

        unique case (state_d)
            S_START: begin
                frame_n_d = 1'b0;
                oe_d      = 1'b1;
                lad_d     = 4'h0;
            end
            S_CYCTYP: begin
                oe_d  = 1'b1;
                lad_d = 4'h2;
            end
            S_ADDR: begin
                oe_d = 1'b1;
                case (idx_d)
                    2'd0:    lad_d = addr_d[15:12];
                    2'd1:    lad_d = addr_d[11:8];
                    2'd2:    lad_d = addr_d[7:4];
                    default: lad_d = addr_d[3:0];
                endcase
            end
            S_DATA: begin
                oe_d  = 1'b1;
                lad_d = (idx_d == 2'd0) ? data_d[3:0] : data_d[7:4];
            end
            S_HTAR1: begin
                oe_d  = 1'b1;
                lad_d = 4'hF;
            end
            S_ABORT: begin
                frame_n_d = 1'b0;
                oe_d      = 1'b1;
                lad_d     = 4'hF;
            end
            default: begin
                frame_n_d = 1'b1;
                oe_d      = 1'b0;
                lad_d     = 4'hF;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            idx_q     <= 2'd0;
            addr_q    <= 16'h0000;
            data_q    <= 8'h00;
            cnt_q     <= 8'd0;
            nr_q      <= 8'd0;
            rslt_q    <= R_OK;
            resp_q    <= R_OK;
            done_q    <= 1'b0;
            ready_q   <= 1'b0;
            lad_q     <= 4'hF;
            oe_q      <= 1'b0;
            frame_n_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            nr_q      <= nr_d;
            rslt_q    <= rslt_d;
            resp_q    <= resp_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
            lad_q     <= lad_d;
            oe_q      <= oe_d;
            frame_n_q <= frame_n_d;
        end
    end

    assign bus.s_tready     = ready_q;
    assign bus.lpc_lad_o    = lad_q;
    assign bus.lpc_lad_oe   = oe_q;
    assign bus.lpc_lframe_n = frame_n_q;
    assign bus.done         = done_q;
    assign bus.resp         = resp_q;

endmodule

// File: tb/tb_diagcard_lpc_io_host.sv
// Directed bench for diagcard_lpc_io_host: vector table of requests
// and peripheral SYNC scripts, plus back-to-back and mid-cycle reset.
module tb_diagcard_lpc_io_host;

    logic clk = 1'b0;
    logic reset;

    always #15 clk = ~clk;

    diagcard_lpc_io_host_if bus();

    diagcard_lpc_io_host #(
        .WAIT_LIMIT  (8),
        .NORESP_LIMIT(3)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // seq: peripheral SYNC nibbles, nibble 0 in bits [3:0]; beyond
    // nseq the peripheral leaves LAD at 1111.  done_c: clock index of
    // done counting START as index 0.
    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        logic [63:0] seq;
        int          nseq;
        logic [1:0]  resp;
        int          done_c;
        bit          abrt;
    } vec_t;

    vec_t vecs[8];
    int   checks = 0;
    int   passed = 0;

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h",
                      name, act, exp);
    endtask

    task automatic periph(input int c, input vec_t v);
        int k;
        k = c - 10;
        if (k >= 0 && k < v.nseq) bus.lpc_lad_i = v.seq[4*k +: 4];
        else bus.lpc_lad_i = 4'hF;
    endtask

    task automatic run_vec(input vec_t v, input int id);
        logic [3:0] nib[9];
        int  e_oe, e_fr, e_lad, e_rdy, dc, w;
        bit  ab, x_oe, x_fr;
        logic rdy_at_done;
        e_oe = 0; e_fr = 0; e_lad = 0; e_rdy = 0;
        dc = -1; w = 0; rdy_at_done = 1'b0;
        nib[0] = 4'h0;
        nib[1] = 4'h2;
        nib[2] = v.addr[15:12];
        nib[3] = v.addr[11:8];
        nib[4] = v.addr[7:4];
        nib[5] = v.addr[3:0];
        nib[6] = v.data[3:0];
        nib[7] = v.data[7:4];
        nib[8] = 4'hF;
        while (bus.s_tready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check($sformatf("v%0d idle ready", id), bus.s_tready, 1);
        bus.s_tvalid = 1'b1;
        bus.s_taddr  = v.addr;
        bus.s_tdata  = v.data;
        @(negedge clk);
        bus.s_tvalid = 1'b0;
        bus.s_taddr  = 16'hFFFF;
        bus.s_tdata  = 8'h00;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) @(negedge clk);
            ab = v.abrt && c >= v.done_c - 5 && c <= v.done_c - 2;
            x_oe = (c <= 8) || ab;
            x_fr = !((c == 0) || ab);
            if (bus.lpc_lad_oe !== x_oe) e_oe++;
            if (bus.lpc_lframe_n !== x_fr) e_fr++;
            if (c <= 8 && bus.lpc_lad_o !== nib[c]) e_lad++;
            if (ab && bus.lpc_lad_o !== 4'hF) e_lad++;
            if (bus.done === 1'b1) begin
                dc = c;
                rdy_at_done = bus.s_tready;
                break;
            end
            if (bus.s_tready !== 1'b0) e_rdy++;
            periph(c, v);
        end
        bus.lpc_lad_i = 4'hF;
        check($sformatf("v%0d lad errs", id), e_lad, 0);
        check($sformatf("v%0d oe errs", id), e_oe, 0);
        check($sformatf("v%0d lframe errs", id), e_fr, 0);
        check($sformatf("v%0d busy ready", id), e_rdy, 0);
        check($sformatf("v%0d done clk", id), dc, v.done_c);
        check($sformatf("v%0d resp", id), bus.resp, v.resp);
        check($sformatf("v%0d ready@done", id), rdy_at_done, 1);
        @(negedge clk);
        check($sformatf("v%0d done width", id), bus.done, 0);
        check($sformatf("v%0d resp hold", id), bus.resp, v.resp);
    endtask

    // Starts at the negedge of START; returns the data nibbles and
    // the clock index of done.  Peripheral answers 0000 at once.
    task automatic capture(output logic [7:0] dat, output int dc);
        dat = 8'h00;
        dc  = -1;
        for (int c = 0; c < 30; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 6) dat[3:0] = bus.lpc_lad_o;
            if (c == 7) dat[7:4] = bus.lpc_lad_o;
            if (bus.done === 1'b1) begin
                dc = c;
                break;
            end
            bus.lpc_lad_i = (c == 10) ? 4'h0 : 4'hF;
        end
        bus.lpc_lad_i = 4'hF;
    endtask

    initial begin
        logic [7:0] d1, d2;
        int dc1, dc2, spur;

        vecs[0] = '{16'h0080, 8'h5A, 64'h0, 1, 2'b00, 13, 1'b0};
        vecs[1] = '{16'h0080, 8'h5A, 64'h0655, 4, 2'b00, 16, 1'b0};
        vecs[2] = '{16'h1234, 8'hC3, 64'h0, 0, 2'b10, 18, 1'b1};
        vecs[3] = '{16'h0080, 8'h11, 64'h66666666, 8, 2'b11, 23, 1'b1};
        vecs[4] = '{16'h03F8, 8'hA5, 64'hA, 1, 2'b01, 13, 1'b0};
        vecs[5] = '{16'h0081, 8'h3C, 64'hFFF5FF, 6, 2'b10, 21, 1'b1};
        vecs[6] = '{16'hBEEF, 8'h96, 64'h0F3, 3, 2'b00, 15, 1'b0};
        vecs[7] = '{16'h0080, 8'hE7, 64'hFF5FF5FF, 8, 2'b11, 23, 1'b1};

        reset         = 1'b1;
        bus.s_tvalid  = 1'b0;
        bus.s_taddr   = 16'h0000;
        bus.s_tdata   = 8'h00;
        bus.lpc_lad_i = 4'hF;
        @(negedge clk);
        @(negedge clk);
        check("reset outputs",
              {bus.s_tready, bus.lpc_lframe_n, bus.lpc_lad_oe,
               bus.lpc_lad_o, bus.done, bus.resp},
              {1'b0, 1'b1, 1'b0, 4'hF, 1'b0, 2'b00});
        reset = 1'b0;
        @(negedge clk);
        check("ready after reset", bus.s_tready, 1);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Reset in the middle of the address phase.
        bus.s_tvalid = 1'b1;
        bus.s_taddr  = 16'h0080;
        bus.s_tdata  = 8'h77;
        @(negedge clk);
        bus.s_tvalid = 1'b0;
        repeat (3) @(negedge clk);
        check("pre-reset oe", bus.lpc_lad_oe, 1);
        reset = 1'b1;
        #1;
        check("mid reset outputs",
              {bus.s_tready, bus.lpc_lframe_n, bus.lpc_lad_oe,
               bus.lpc_lad_o, bus.done, bus.resp},
              {1'b0, 1'b1, 1'b0, 4'hF, 1'b0, 2'b00});
        spur = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done !== 1'b0) spur++;
        end
        reset = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done !== 1'b0) spur++;
            if (bus.lpc_lframe_n !== 1'b1) spur++;
        end
        check("no done after reset", spur, 0);
        run_vec(vecs[0], 8);

        // Back-to-back with s_tvalid held high.
        bus.s_tvalid = 1'b1;
        bus.s_taddr  = 16'h0080;
        bus.s_tdata  = 8'h01;
        @(negedge clk);
        capture(d1, dc1);
        check("b2b first done clk", dc1, 13);
        check("b2b first data", d1, 8'h01);
        check("b2b ready@done", bus.s_tready, 1);
        bus.s_tdata = 8'h02;
        @(negedge clk);
        check("b2b second start",
              {bus.lpc_lframe_n, bus.lpc_lad_oe, bus.lpc_lad_o},
              {1'b0, 1'b1, 4'h0});
        bus.s_tvalid = 1'b0;
        capture(d2, dc2);
        check("b2b second done clk", dc2, 13);
        check("b2b second data", d2, 8'h02);
        check("b2b second resp", bus.resp, 2'b00);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
